// File: rtl/stage_ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Holds the md op encodings used by the controller and the unit, the FSM
// state type, and a helper that classifies long-latency ops.
package stage_ex_muldiv_pkg;

    localparam int MD_OP_LEN = 3;

    typedef enum logic [MD_OP_LEN-1:0] {
        MD_OP_NONE  = 3'd0,
        MD_OP_MULT  = 3'd1,
        MD_OP_MULTU = 3'd2,
        MD_OP_DIV   = 3'd3,
        MD_OP_DIVU  = 3'd4,
        MD_OP_MTHI  = 3'd5,
        MD_OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [MD_OP_LEN-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/stage_ex_muldiv.sv
// Multiply/divide unit of EX: owns HI/LO, runs MULT/MULTU/DIV/DIVU, executes MTHI/MTLO.
// Latency: MULT* busy MULT_CYCLES cycles, DIV* busy DIV_CYCLES cycles, HI/LO update on the
// final edge; MTHI/MTLO write in 1 cycle. Any start while busy is dropped (no stall output).
// Ports: clk, reset (sync, active-high), start/op/a/b (request), busy/hi/lo (registered).
module stage_ex_muldiv
    import stage_ex_muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MD_OP_LEN-1:0] op,
    input  logic [31:0]          a,
    input  logic [31:0]          b,
    output logic                 busy,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               commit_en_q, commit_en_d;
    logic [31:0]        hi_d, lo_d;

    // Arithmetic: operands widened to 64 bits so the signed divide of
    // 0x80000000 by -1 yields +2^31, whose low word is 0x80000000 with rem 0.
    logic signed [63:0] a_sx, b_sx, bnz_sx;
    logic signed [63:0] prod_s, quot_s, rem_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_nz;
    logic        [31:0] res_hi, res_lo;
    logic               is_div;

    always_comb begin
        // A zero divisor is replaced by 1 purely to keep the divider defined;
        // the result is discarded through commit_en.
        b_nz   = (b == 32'd0) ? 32'd1 : b;
        a_sx   = {{32{a[31]}}, a};
        b_sx   = {{32{b[31]}}, b};
        bnz_sx = {{32{b_nz[31]}}, b_nz};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, a} * {32'd0, b};
        quot_s = a_sx / bnz_sx;
        rem_s  = a_sx % bnz_sx;
        is_div = (op == MD_OP_DIV) || (op == MD_OP_DIVU);
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_OP_DIV: begin
                res_hi = rem_s[31:0];
                res_lo = quot_s[31:0];
            end
            MD_OP_DIVU: begin
                res_hi = a % b_nz;
                res_lo = a / b_nz;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // Next-state / commit logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        commit_en_d = commit_en_q;
        hi_d        = hi;
        lo_d        = lo;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(op)) begin
                        state_d     = ST_RUN;
                        cnt_d       = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        pend_hi_d   = res_hi;
                        pend_lo_d   = res_lo;
                        commit_en_d = !(is_div && (b == 32'd0));
                    end else if (op == MD_OP_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                // Requests arriving here are dropped; busy is still high.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (commit_en_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            commit_en_q <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            commit_en_q <= commit_en_d;
            hi          <= hi_d;
            lo          <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Self-checking bench for stage_ex_muldiv: directed cases with literal
// expectations plus randomized traffic against a timestamp-based model.
module tb_stage_ex_muldiv;
    import stage_ex_muldiv_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [MD_OP_LEN-1:0] op;
    logic [31:0]          a, b;
    logic                 busy;
    logic [31:0]          hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    stage_ex_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An accepted long op is represented by the absolute edge index at which
    // it completes; the unit is busy until that edge has passed.
    longint     cyc = 0;
    bit         m_pend = 1'b0;
    longint     m_done_at = 0;
    bit         m_en = 1'b0;
    bit [31:0]  m_res_hi, m_res_lo;
    bit [31:0]  m_hi = 0, m_lo = 0;
    bit         m_busy = 1'b0;

    function automatic void ref_compute(input logic [MD_OP_LEN-1:0] o, input bit [31:0] x,
                                        input bit [31:0] y, output bit [31:0] rh,
                                        output bit [31:0] rl);
        longint          ps;
        longint unsigned pu;
        bit [31:0]       ma, mb, q, r;
        rh = 0; rl = 0;
        case (o)
            MD_OP_MULT: begin
                ps = longint'($signed(x)) * longint'($signed(y));
                rh = ps[63:32]; rl = ps[31:0];
            end
            MD_OP_MULTU: begin
                pu = longint'({32'd0, x}) * longint'({32'd0, y});
                rh = pu[63:32]; rl = pu[31:0];
            end
            MD_OP_DIV: if (y != 0) begin
                // Divide magnitudes, then reapply signs (truncation toward zero).
                ma = x[31] ? (~x + 1) : x;
                mb = y[31] ? (~y + 1) : y;
                q  = ma / mb;
                r  = ma % mb;
                if (x[31] != y[31]) q = ~q + 1;
                if (x[31]) r = ~r + 1;
                rh = r; rl = q;
            end
            MD_OP_DIVU: if (y != 0) begin
                rh = x % y; rl = x / y;
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        bit was_busy;
        cyc++;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_pend = 0; m_busy = 0;
        end else begin
            was_busy = m_pend;
            if (m_pend && cyc == m_done_at) begin
                if (m_en) begin m_hi = m_res_hi; m_lo = m_res_lo; end
                m_pend = 0;
            end
            if (start && !was_busy) begin
                if (is_long_op(op)) begin
                    ref_compute(op, a, b, m_res_hi, m_res_lo);
                    m_pend    = 1;
                    m_done_at = cyc + ((op == MD_OP_DIV || op == MD_OP_DIVU) ? DC : MC);
                    m_en      = !((op == MD_OP_DIV || op == MD_OP_DIVU) && b == 0);
                end else if (op == MD_OP_MTHI) begin
                    m_hi = a;
                end else if (op == MD_OP_MTLO) begin
                    m_lo = a;
                end
            end
            m_busy = m_pend;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [MD_OP_LEN-1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = MD_OP_NONE;
    endtask

    task automatic wait_idle(output int nb);
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        if (nb >= 100) begin
            n_checks++; n_errors++;
            $display("FAIL wait_idle: busy stuck high after %0d cycles", nb);
        end
    endtask

    int nb;
    logic [31:0] ra, rb;

    initial begin
        reset = 1'b1; start = 1'b0; op = MD_OP_NONE; a = 0; b = 0;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1. signed multiply
        issue(MD_OP_MULT, 32'hFFFFFFFE, 32'd3);
        check("t1_hold_hi", hi, 32'd0);
        wait_idle(nb);
        check("t1_busy_len", nb, MC);
        check("t1_hi", hi, 32'hFFFFFFFF);
        check("t1_lo", lo, 32'hFFFFFFFA);

        // 2. unsigned multiply
        issue(MD_OP_MULTU, 32'hFFFFFFFE, 32'd3);
        wait_idle(nb);
        check("t2_busy_len", nb, MC);
        check("t2_hi", hi, 32'h00000002);
        check("t2_lo", lo, 32'hFFFFFFFA);

        // 3. signed then unsigned divide
        issue(MD_OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(nb);
        check("t3_busy_len", nb, DC);
        check("t3_div_lo", lo, 32'hFFFFFFFD);
        check("t3_div_hi", hi, 32'hFFFFFFFF);
        issue(MD_OP_DIVU, 32'd7, 32'd2);
        wait_idle(nb);
        check("t3_divu_lo", lo, 32'd3);
        check("t3_divu_hi", hi, 32'd1);

        // overflow case of signed divide
        issue(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(nb);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'd0);

        // 4. MTHI/MTLO then divide by zero
        issue(MD_OP_MTHI, 32'h1234, 32'd0);
        check("t4_mthi", hi, 32'h1234);
        check("t4_mthi_busy", {31'd0, busy}, 32'd0);
        issue(MD_OP_MTLO, 32'h5678, 32'd0);
        check("t4_mtlo", lo, 32'h5678);
        issue(MD_OP_DIV, 32'd5, 32'd0);
        wait_idle(nb);
        check("t4_busy_len", nb, DC);
        check("t4_hi", hi, 32'h1234);
        check("t4_lo", lo, 32'h5678);

        // 5. start while busy is dropped; start on completion edge waits a cycle
        issue(MD_OP_MULT, 32'h00010000, 32'h00010000);
        @(negedge clk);
        start = 1'b1; op = MD_OP_MTLO; a = 32'hAAAA;
        @(negedge clk);
        start = 1'b0; op = MD_OP_NONE;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = MD_OP_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        check("t5_busy_done", {31'd0, busy}, 32'd0);
        check("t5_hi", hi, 32'd1);
        check("t5_lo", lo, 32'd0);
        @(negedge clk);
        start = 1'b0; op = MD_OP_NONE;
        check("t5_reaccept", {31'd0, busy}, 32'd1);
        wait_idle(nb);
        check("t5_divu_lo", lo, 32'd14);
        check("t5_divu_hi", hi, 32'd2);

        // 6. reset mid divide
        issue(MD_OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_hi", hi, 32'd0);
        check("t6_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check("t6_no_commit_hi", hi, 32'd0);
        check("t6_no_commit_lo", lo, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (m_busy) start = ($urandom_range(0, 9) == 0);
            else        start = ($urandom_range(0, 1) == 0);
            op = MD_OP_LEN'($urandom_range(0, 6));
            case ($urandom_range(0, 5))
                0: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                1: begin ra = $urandom; rb = 32'd0; end
                2: begin ra = $urandom_range(0, 50) - 25; rb = $urandom_range(0, 10) - 5; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            a = ra; b = rb;
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0; op = MD_OP_NONE;
        wait_idle(nb);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
